// File: rtl/spawn_if.sv
// Obstacle-spawn handshake bundle between the scheduler, the LFSR and the
// bird/cactus objects. The slave side is the scheduler itself.
interface spawn_if;
    logic        en_i;
    logic        frame_i;
    logic [15:0] rand_i;
    logic        cactus_spawn_o;
    logic        bird_spawn_o;
    logic        rand_next_o;
    logic [1:0]  level_o;

    modport master (
        output en_i, frame_i, rand_i,
        input  cactus_spawn_o, bird_spawn_o, rand_next_o, level_o
    );

    modport slave (
        input  en_i, frame_i, rand_i,
        output cactus_spawn_o, bird_spawn_o, rand_next_o, level_o
    );
endinterface

// File: rtl/spawn_scheduler.sv
// Once per video frame decides whether a cactus or bird enters the playfield,
// enforcing a frame-counted cooldown between obstacles and a difficulty level
// that ramps with play time. Also requests the next LFSR word every played frame.
module spawn_scheduler #(
    parameter int unsigned MIN_GAP_FRAMES = 40,
    parameter int unsigned LEVEL_FRAMES   = 1800
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    clr_i,
    spawn_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COOLDOWN = 2'd1,
        ARMED    = 2'd2
    } state_t;

    localparam logic [7:0]  MIN_GAP  = 8'(MIN_GAP_FRAMES);
    localparam logic [10:0] LVL_LAST = 11'(LEVEL_FRAMES - 1);

    // Spawn probability threshold on rand[7:0] doubles with each level.
    function automatic logic [7:0] spawn_threshold(input logic [1:0] lvl);
        logic [7:0] thr;
        case (lvl)
            2'd0:    thr = 8'd8;
            2'd1:    thr = 8'd16;
            2'd2:    thr = 8'd32;
            2'd3:    thr = 8'd64;
            default: thr = 8'd8;
        endcase
        return thr;
    endfunction

    // Post-spawn cooldown: base gap plus a random 0..15 extra, saturating.
    function automatic logic [7:0] gap_load(input logic [3:0] extra);
        logic [8:0] sum;
        sum = {1'b0, MIN_GAP} + {5'd0, extra};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    state_t      state_q,  state_d;
    logic [7:0]  gap_q,    gap_d;
    logic [10:0] lvl_cnt_q, lvl_cnt_d;
    logic [1:0]  level_q,  level_d;
    logic        cactus_q, cactus_d;
    logic        bird_q,   bird_d;
    logic        next_q,   next_d;

    logic        spawn_hit_s;
    logic        unused_rand_s;

    assign spawn_hit_s   = (bus.rand_i[7:0] < spawn_threshold(level_q));
    assign unused_rand_s = ^bus.rand_i[14:12];

    // Next-state, cooldown, difficulty and pulse decisions for one cycle.
    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        lvl_cnt_d = lvl_cnt_q;
        level_d   = level_q;
        cactus_d  = 1'b0;
        bird_d    = 1'b0;
        next_d    = 1'b0;

        if (!bus.en_i) begin
            // Leaving PLAYING (or not yet in it): drop to IDLE, keep the level.
            state_d = IDLE;
            gap_d   = 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = COOLDOWN;
                    gap_d   = MIN_GAP;
                end
                COOLDOWN: begin
                    if (bus.frame_i) begin
                        if (gap_q <= 8'd1) begin
                            gap_d   = 8'd0;
                            state_d = ARMED;
                        end else begin
                            gap_d   = gap_q - 8'd1;
                        end
                    end else begin
                        gap_d = gap_q;
                    end
                end
                ARMED: begin
                    if (bus.frame_i && spawn_hit_s) begin
                        if (bus.rand_i[15] && (level_q != 2'd0)) begin
                            bird_d = 1'b1;
                        end else begin
                            cactus_d = 1'b1;
                        end
                        gap_d   = gap_load(bus.rand_i[11:8]);
                        state_d = COOLDOWN;
                    end else begin
                        state_d = ARMED;
                    end
                end
                default: begin
                    state_d = IDLE;
                    gap_d   = 8'd0;
                end
            endcase

            // Play-time difficulty ramp; spawn above used the pre-update level.
            if (bus.frame_i) begin
                next_d = (state_q != IDLE);
                if (lvl_cnt_q == LVL_LAST) begin
                    lvl_cnt_d = 11'd0;
                    level_d   = (level_q == 2'd3) ? 2'd3 : level_q + 2'd1;
                end else begin
                    lvl_cnt_d = lvl_cnt_q + 11'd1;
                end
            end else begin
                next_d = 1'b0;
            end
        end
    end

    // State and output registers; reset and new-game clear are equivalent.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            state_q   <= IDLE;
            gap_q     <= 8'd0;
            lvl_cnt_q <= 11'd0;
            level_q   <= 2'd0;
            cactus_q  <= 1'b0;
            bird_q    <= 1'b0;
            next_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            lvl_cnt_q <= lvl_cnt_d;
            level_q   <= level_d;
            cactus_q  <= cactus_d;
            bird_q    <= bird_d;
            next_q    <= next_d;
        end
    end

    assign bus.cactus_spawn_o = cactus_q;
    assign bus.bird_spawn_o   = bird_q;
    assign bus.rand_next_o    = next_q;
    assign bus.level_o        = level_q;
endmodule

// File: tb/tb_spawn_scheduler.sv
// Self-checking bench for spawn_scheduler: directed test-plan steps plus a
// randomized phase, every cycle compared against a frame-level reference model.
module tb_spawn_scheduler;
    localparam int MG = 40;
    localparam int LF = 1800;

    logic clk;
    logic rst;
    logic clr;

    spawn_if bus();

    spawn_scheduler #(.MIN_GAP_FRAMES(MG), .LEVEL_FRAMES(LF)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (clr),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: frames of waiting left, enabled-frame count since clear.
    bit m_active = 1'b0;
    int m_wait   = 0;
    int m_frames = 0;
    bit exp_c, exp_b, exp_n;
    int exp_lvl;

    int pf;
    int c_q[$];
    int b_q[$];

    function automatic int lvl_of(input int f);
        int l;
        l = f / LF;
        return (l > 3) ? 3 : l;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit r_rst, input bit c_clr, input bit e, input bit f,
                              input logic [15:0] r);
        int lv;
        int g;
        exp_c = 1'b0;
        exp_b = 1'b0;
        exp_n = 1'b0;
        if (r_rst || c_clr) begin
            m_active = 1'b0;
            m_wait   = 0;
            m_frames = 0;
        end else if (!e) begin
            m_active = 1'b0;
        end else begin
            if (f) begin
                lv = lvl_of(m_frames);
                if (m_active) begin
                    exp_n = 1'b1;
                    if (m_wait > 0) begin
                        m_wait--;
                    end else if (int'(r[7:0]) < (8 << lv)) begin
                        if (r[15] && lv >= 1) exp_b = 1'b1;
                        else exp_c = 1'b1;
                        g = MG + int'(r[11:8]);
                        m_wait = (g > 255) ? 255 : g;
                    end
                end
                m_frames++;
            end
            if (!m_active) begin
                m_active = 1'b1;
                m_wait   = MG;
            end
        end
        exp_lvl = lvl_of(m_frames);
    endtask

    task automatic tick(input bit r_rst, input bit c_clr, input bit e, input bit f,
                        input logic [15:0] r);
        rst         = r_rst;
        clr         = c_clr;
        bus.en_i    = e;
        bus.frame_i = f;
        bus.rand_i  = r;
        model_step(r_rst, c_clr, e, f, r);
        @(posedge clk);
        #1;
        check("cactus", 32'(bus.cactus_spawn_o), 32'(exp_c));
        check("bird",   32'(bus.bird_spawn_o),   32'(exp_b));
        check("rnext",  32'(bus.rand_next_o),    32'(exp_n));
        check("level",  32'(bus.level_o),        32'(exp_lvl));
        check("onehot", 32'(bus.cactus_spawn_o & bus.bird_spawn_o), 32'd0);
    endtask

    task automatic play_frame(input logic [15:0] r);
        tick(1'b0, 1'b0, 1'b1, 1'b1, r);
        pf++;
        if (bus.cactus_spawn_o === 1'b1) c_q.push_back(pf);
        if (bus.bird_spawn_o === 1'b1) b_q.push_back(pf);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 16'($urandom));
    endtask

    task automatic new_game();
        tick(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        pf = 0;
        c_q.delete();
        b_q.delete();
    endtask

    initial begin
        bit e;
        bit f;
        bit c;
        rst = 1'b1; clr = 1'b0;
        bus.en_i = 1'b0; bus.frame_i = 1'b0; bus.rand_i = 16'h0000;

        // Reset state, then reset mid-cooldown, then 100 disabled frames.
        tick(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        for (int i = 0; i < 20; i++) play_frame(16'h0000);
        tick(1'b1, 1'b0, 1'b1, 1'b1, 16'h0000);
        for (int i = 0; i < 100; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b1, 16'($urandom));
            tick(1'b0, 1'b0, 1'b0, 1'b0, 16'($urandom));
        end

        // Grace and gap with rand=0: cactus on frames 41 and 82.
        new_game();
        for (int i = 0; i < 90; i++) play_frame(16'h0000);
        check("grace_count", 32'(c_q.size()), 32'd2);
        check("grace_first", 32'(c_q.size() > 0 ? c_q[0] : -1), 32'd41);
        check("gap_second",  32'(c_q.size() > 1 ? c_q[1] : -1), 32'd82);
        check("grace_nobird", 32'(b_q.size()), 32'd0);

        // Threshold: 8 never spawns at level 0, 7 does.
        for (int i = 0; i < 60; i++) play_frame(16'h0008);
        check("thr_eq8", 32'(c_q.size()), 32'd2);
        play_frame(16'h0007);
        check("thr_lt8", 32'(c_q.size()), 32'd3);
        check("thr_frame", 32'(c_q.size() > 2 ? c_q[2] : -1), 32'd151);

        // Random gap: extra 15 frames of cooldown.
        new_game();
        for (int i = 0; i < 100; i++) play_frame(16'h0F00);
        check("rgap_count", 32'(c_q.size()), 32'd2);
        check("rgap_first", 32'(c_q.size() > 0 ? c_q[0] : -1), 32'd41);
        check("rgap_second", 32'(c_q.size() > 1 ? c_q[1] : -1), 32'd97);

        // Level ramp and spawn type switch.
        new_game();
        for (int i = 0; i < LF - 1; i++) play_frame(16'h8000);
        check("lvl0_hold", 32'(bus.level_o), 32'd0);
        play_frame(16'h8000);
        check("lvl1_step", 32'(bus.level_o), 32'd1);
        check("lvl0_cactus", 32'(c_q.size() > 0), 32'd1);
        check("lvl0_nobird", 32'(b_q.size()), 32'd0);
        c_q.delete(); b_q.delete();
        for (int i = 0; i < 1900; i++) play_frame(16'h8000);
        check("lvl1_nocactus", 32'(c_q.size()), 32'd0);
        check("lvl1_bird", 32'(b_q.size() > 0), 32'd1);
        check("lvl2_reached", 32'(bus.level_o), 32'd2);

        // Hit freeze: en drops with a frame at level 2.
        tick(1'b0, 1'b0, 1'b0, 1'b1, 16'h8000);
        check("hit_rnext", 32'(bus.rand_next_o), 32'd0);
        check("hit_spawn", 32'(bus.cactus_spawn_o | bus.bird_spawn_o), 32'd0);
        check("hit_level", 32'(bus.level_o), 32'd2);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b0, 1'b1, 16'h8000);
        check("frozen_level", 32'(bus.level_o), 32'd2);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 16'h8000);
        pf = 0; c_q.delete(); b_q.delete();
        for (int i = 0; i < 41; i++) play_frame(16'h8000);
        check("regrace_count", 32'(b_q.size()), 32'd1);
        check("regrace_frame", 32'(b_q.size() > 0 ? b_q[0] : -1), 32'd41);

        // Saturation at level 3, then clear.
        for (int i = 0; i < 1800; i++) play_frame(16'h8000);
        check("lvl3_sat", 32'(bus.level_o), 32'd3);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 16'h8000);
        check("clr_level", 32'(bus.level_o), 32'd0);

        // Randomized play with disables, same-cycle drops and clears.
        for (int i = 0; i < 4000; i++) begin
            e = ($urandom_range(0, 19) != 0);
            f = ($urandom_range(0, 1) == 1);
            c = ($urandom_range(0, 499) == 0);
            tick(1'b0, c, e, f, 16'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spawn_scheduler.md
# spawn_scheduler

Decides when obstacles enter the playfield during a dinorun game. It sits between `lfsr16` and the `bird`/`cactus` objects. Once per video frame it samples the random word and issues one-cycle spawn pulses to those objects. It enforces a minimum gap between obstacles and ramps difficulty with play time. It also requests the next LFSR value once per frame.

## Interface
- `MIN_GAP_FRAMES`, default 40: frames of forced cooldown after game start and after every spawn (width 8, 1..255).
- `LEVEL_FRAMES`, default 1800: play frames per difficulty level step (30 s at 60 Hz), 1..2047.
- `clk_i`, input, 1: 25.175 MHz pixel clock. One clock domain.
- `rst_i`, input, 1: reset, synchronous, active-high. Clears all state.
- `clr_i`, input, 1: synchronous new-game clear. Same effect as `rst_i`; `rst_i` has priority.
- `en_i`, input, 1: high while the game FSM is in PLAYING.
- `frame_i`, input, 1: one-cycle pulse per frame, from the edge detector on vsync.
- `rand_i`, input, 16: current LFSR word.
- `cactus_spawn_o`, output, 1: one-cycle spawn pulse to `cactus`.
- `bird_spawn_o`, output, 1: one-cycle spawn pulse to `bird`.
- `rand_next_o`, output, 1: one-cycle LFSR advance request.
- `level_o`, output, 2: current difficulty level, 0..3.

## Operation
Internal state:
- States: IDLE, COOLDOWN, ARMED.
- 8-bit `gap_q`: counts frames, not cycles.
- 11-bit `lvl_cnt_q`.
- 2-bit `level_q`.

Transitions:
- **IDLE:** on `en_i`=1, go to COOLDOWN and load `gap_q`=MIN_GAP_FRAMES in the same cycle. This is the start-of-game grace period.
- **COOLDOWN:** on each `frame_i`, decrement `gap_q`. On the `frame_i` that makes it 0, go to ARMED.
- **ARMED:** on each `frame_i`, evaluate a spawn.
  - Spawn when `rand_i[7:0]` < T(level), strictly less. T = 8, 16, 32, 64 for levels 0..3.
  - Type: bird when `rand_i[15]`=1 and level ≥ 1; otherwise cactus.
  - On spawn, go to COOLDOWN and load `gap_q` = MIN_GAP_FRAMES + `rand_i[11:8]` (9-bit sum, saturate at 255).
  - No spawn: remain ARMED.

Difficulty:
- While `en_i`=1, each `frame_i` increments `lvl_cnt_q`.
- When `lvl_cnt_q` reaches LEVEL_FRAMES-1 on a frame, it wraps to 0 and `level_q` increments, saturating at 3.
- The spawn decision on that same frame uses the pre-increment level.

LFSR advance: `rand_next_o` pulses for every `frame_i` while `en_i`=1, in any state except IDLE.

Disable behaviour:
- `en_i`=0 forces IDLE from any state and clears `gap_q`.
- `level_q` and `lvl_cnt_q` hold, so the HIT freeze keeps the level.
- A new game starts with `clr_i`.

Boundary rules:
- `frame_i` and `en_i` falling in the same cycle: no spawn, no `rand_next_o`, go to IDLE.
- `rst_i` or `clr_i` mid-cooldown or mid-spawn: the pulse is suppressed and everything returns to reset values next cycle.
- At most one spawn output is high per frame; `cactus_spawn_o` and `bird_spawn_o` are never high together.

## Timing
- Reset values: `cactus_spawn_o`=0, `bird_spawn_o`=0, `rand_next_o`=0, `level_o`=0, state IDLE, `gap_q`=0, `lvl_cnt_q`=0.
- All outputs are registered.
- `rand_i` is sampled in the cycle where `frame_i`=1.
- Spawn pulses and `rand_next_o` are high exactly one cycle, in the cycle after the `frame_i` cycle.
- The LFSR therefore advances after sampling, so no word is reused across frames.
- `level_o` updates the cycle after the qualifying `frame_i`.
- First possible spawn: the (MIN_GAP_FRAMES+1)-th frame after `en_i` rises.
- Consecutive spawns are at least MIN_GAP_FRAMES+1 frames apart.

## Test plan
- **Reset and idle.** Stimulus: assert `rst_i` mid-cooldown, then hold `en_i`=0 while pulsing `frame_i` 100 times. Required: all outputs 0, including `rand_next_o`.
- **Grace and gap.** Stimulus: `rand_i`=0x0000, `en_i`=1, frame pulses. Required: `cactus_spawn_o` on frames 41 and 82 only, and each pulse is one cycle wide. Required: `rand_next_o` on every frame.
- **Threshold.** Stimulus: level 0, ARMED, `rand_i[7:0]`=8. Required: no spawn, state stays ARMED. Then `rand_i[7:0]`=7. Required: cactus spawn.
- **Random gap.** Stimulus: spawn with `rand_i`=0x0F00. Required: next eligible spawn 56 frames later.
- **Level ramp and type.** Stimulus: `rand_i`=0x8000, play frames beyond 1800. Required: `level_o` 0→1 after frame 1800, and spawns switch from cactus to bird.
  - Level saturates at 3 after 5400 frames.
  - `clr_i` returns it to 0.
- **Hit freeze.** Stimulus: drop `en_i` on the same cycle as `frame_i` at level 2. Required: no spawn pulse and no `rand_next_o`, `level_o` stays 2. After re-enable, a fresh 40-frame grace period applies.
